// File: rtl/sa_write_arbiter_pkg.sv
// Shared types and sizing helpers for the slave-side write arbiter.
// The AW grant FSM states live here, together with the width helpers that
// size the routing-queue occupancy counters and the master index.
package sa_write_arbiter_pkg;

  typedef enum logic {
    AW_IDLE  = 1'b0,  // looking for an eligible AW request
    AW_GRANT = 1'b1   // presenting the granted AW to the slave
  } aw_state_e;

  // Occupancy counters carry one extra bit so "full" (count == depth) is
  // distinguishable from "empty" without comparing pointers.
  function automatic int queue_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Index width that never collapses to zero bits for a single entry.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sa_id_fifo.sv
// Synchronous FIFO of master indices. The arbiter uses two of these: one
// orders W bursts, the other orders B responses, both in AW-grant order.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   push_i, push_data_i    write one entry (ignored when full)
//   pop_i                  drop the head entry (ignored when empty)
//   head_o                 current head entry, valid while !empty_o
//   full_o, empty_o        occupancy flags
module sa_id_fifo
  import sa_write_arbiter_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int CNT_W = queue_cnt_w(DEPTH);
  localparam int PTR_W = idx_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointers wrap modulo DEPTH, so non-power-of-two depths work as well.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      // A simultaneous push and pop leaves the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; an empty FIFO never exposes its
  // contents, so clearing it would only cost reset fan-out.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/sa_write_arbiter.sv
// Slave-side write-channel arbiter. Collects AW/W requests from MST_AMT
// dispatchers bound for one slave, grants one AW at a time round-robin,
// steers W bursts to the slave in AW-grant order and routes each B response
// back to the master whose AW it answers.
//
// Ports:
//   ACLK_i, ARESETn_i            clock, asynchronous active-low reset
//   dsp_AW*_i, dsp_AWVALID_i     packed per-master AW requests
//   dsp_AW_outst_full_i          per-master mask: dispatcher cannot take more
//   dsp_AWREADY_o                per-master AW accept
//   dsp_W*_i, dsp_WREADY_o       packed per-master W channel
//   dsp_BID_o, dsp_BRESP_o       B payload broadcast to all masters
//   dsp_BVALID_o, dsp_BREADY_i   per-master B handshake
//   s_AW*, s_W*, s_B*            single slave port
module sa_write_arbiter
  import sa_write_arbiter_pkg::*;
#(
  parameter int MST_AMT           = 2,
  parameter int OUTSTANDING_AMT   = 8,
  parameter int DATA_WIDTH        = 32,
  parameter int ADDR_WIDTH        = 32,
  parameter int TRANS_MST_ID_W    = 5,
  parameter int TRANS_BURST_W     = 2,
  parameter int TRANS_DATA_LEN_W  = 3,
  parameter int TRANS_DATA_SIZE_W = 3,
  parameter int TRANS_WR_RESP_W   = 2,
  parameter int MST_ID_W          = $clog2(MST_AMT)
) (
  input  logic                                   ACLK_i,
  input  logic                                   ARESETn_i,
  // AW from dispatchers
  input  logic [MST_AMT*TRANS_MST_ID_W-1:0]      dsp_AWID_i,
  input  logic [MST_AMT*ADDR_WIDTH-1:0]          dsp_AWADDR_i,
  input  logic [MST_AMT*TRANS_BURST_W-1:0]       dsp_AWBURST_i,
  input  logic [MST_AMT*TRANS_DATA_LEN_W-1:0]    dsp_AWLEN_i,
  input  logic [MST_AMT*TRANS_DATA_SIZE_W-1:0]   dsp_AWSIZE_i,
  input  logic [MST_AMT-1:0]                     dsp_AWVALID_i,
  input  logic [MST_AMT-1:0]                     dsp_AW_outst_full_i,
  output logic [MST_AMT-1:0]                     dsp_AWREADY_o,
  // W from dispatchers
  input  logic [MST_AMT*DATA_WIDTH-1:0]          dsp_WDATA_i,
  input  logic [MST_AMT-1:0]                     dsp_WLAST_i,
  input  logic [MST_AMT-1:0]                     dsp_WVALID_i,
  output logic [MST_AMT-1:0]                     dsp_WREADY_o,
  // B to dispatchers
  output logic [TRANS_MST_ID_W-1:0]              dsp_BID_o,
  output logic [TRANS_WR_RESP_W-1:0]             dsp_BRESP_o,
  output logic [MST_AMT-1:0]                     dsp_BVALID_o,
  input  logic [MST_AMT-1:0]                     dsp_BREADY_i,
  // AW to slave
  output logic [TRANS_MST_ID_W-1:0]              s_AWID_o,
  output logic [ADDR_WIDTH-1:0]                  s_AWADDR_o,
  output logic [TRANS_BURST_W-1:0]               s_AWBURST_o,
  output logic [TRANS_DATA_LEN_W-1:0]            s_AWLEN_o,
  output logic [TRANS_DATA_SIZE_W-1:0]           s_AWSIZE_o,
  output logic                                   s_AWVALID_o,
  input  logic                                   s_AWREADY_i,
  // W to slave
  output logic [DATA_WIDTH-1:0]                  s_WDATA_o,
  output logic                                   s_WLAST_o,
  output logic                                   s_WVALID_o,
  input  logic                                   s_WREADY_i,
  // B from slave
  input  logic [TRANS_MST_ID_W-1:0]              s_BID_i,
  input  logic [TRANS_WR_RESP_W-1:0]             s_BRESP_i,
  input  logic                                   s_BVALID_i,
  output logic                                   s_BREADY_o
);

  localparam int IDX_W = (MST_ID_W > 0) ? MST_ID_W : 1;

  // Per-master views of the packed request buses.
  logic [TRANS_MST_ID_W-1:0]    aw_id    [MST_AMT];
  logic [ADDR_WIDTH-1:0]        aw_addr  [MST_AMT];
  logic [TRANS_BURST_W-1:0]     aw_burst [MST_AMT];
  logic [TRANS_DATA_LEN_W-1:0]  aw_len   [MST_AMT];
  logic [TRANS_DATA_SIZE_W-1:0] aw_size  [MST_AMT];
  logic [DATA_WIDTH-1:0]        w_data   [MST_AMT];

  for (genvar g = 0; g < MST_AMT; g++) begin : g_unpack
    assign aw_id[g]    = dsp_AWID_i[g*TRANS_MST_ID_W +: TRANS_MST_ID_W];
    assign aw_addr[g]  = dsp_AWADDR_i[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign aw_burst[g] = dsp_AWBURST_i[g*TRANS_BURST_W +: TRANS_BURST_W];
    assign aw_len[g]   = dsp_AWLEN_i[g*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
    assign aw_size[g]  = dsp_AWSIZE_i[g*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
    assign w_data[g]   = dsp_WDATA_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  aw_state_e        state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] pick_idx, cand;
  logic [IDX_W:0]   cand_sum;
  logic             pick_vld;
  logic [MST_AMT-1:0] eligible;

  logic             q_push;
  logic [IDX_W-1:0] wq_head, bq_head;
  logic             wq_full, wq_empty, wq_pop;
  logic             bq_full, bq_empty, bq_pop;

  // A dispatcher whose outstanding tracker is full must not be granted.
  assign eligible = dsp_AWVALID_i & ~dsp_AW_outst_full_i;

  // Round-robin pick: first eligible index at or after rr_ptr, wrapping.
  // NOTE: every variable driven here gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pick_idx = '0;
    pick_vld = 1'b0;
    cand     = '0;
    cand_sum = '0;
    for (int i = 0; i < MST_AMT; i++) begin
      cand_sum = {1'b0, rr_ptr_q} + (IDX_W + 1)'(i);
      if (cand_sum >= (IDX_W + 1)'(MST_AMT)) cand_sum = cand_sum - (IDX_W + 1)'(MST_AMT);
      cand = cand_sum[IDX_W-1:0];
      if (!pick_vld && eligible[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // AW grant FSM: next state.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    q_push   = 1'b0;
    case (state_q)
      AW_IDLE: begin
        // Both routing queues must have room before an AW may leave.
        if (pick_vld && !wq_full && !bq_full) begin
          grant_d = pick_idx;
          state_d = AW_GRANT;
        end
      end
      AW_GRANT: begin
        if (s_AWREADY_i) begin
          q_push   = 1'b1;
          rr_ptr_d = (grant_q == IDX_W'(MST_AMT - 1)) ? '0 : grant_q + 1'b1;
          state_d  = AW_IDLE;
        end
      end
      default: state_d = AW_IDLE;
    endcase
  end

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      state_q  <= AW_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // AW channel: payload comes straight from the granted master, which holds
  // it stable until the handshake.
  assign s_AWVALID_o = (state_q == AW_GRANT);
  assign s_AWID_o    = aw_id[grant_q];
  assign s_AWADDR_o  = aw_addr[grant_q];
  assign s_AWBURST_o = aw_burst[grant_q];
  assign s_AWLEN_o   = aw_len[grant_q];
  assign s_AWSIZE_o  = aw_size[grant_q];

  always_comb begin
    dsp_AWREADY_o = '0;
    if (state_q == AW_GRANT) dsp_AWREADY_o[grant_q] = s_AWREADY_i;
  end

  // W channel: the head of the W queue owns the slave's W port until its
  // WLAST handshake; beats are not counted.
  assign s_WVALID_o = ~wq_empty & dsp_WVALID_i[wq_head];
  assign s_WDATA_o  = w_data[wq_head];
  assign s_WLAST_o  = dsp_WLAST_i[wq_head];
  assign wq_pop     = s_WVALID_o & s_WREADY_i & s_WLAST_o;

  always_comb begin
    dsp_WREADY_o = '0;
    if (!wq_empty) dsp_WREADY_o[wq_head] = s_WREADY_i;
  end

  // B channel: the slave answers in AW-acceptance order, so the head of the
  // B queue names the owner. A response with no queued owner is held off.
  assign dsp_BID_o   = s_BID_i;
  assign dsp_BRESP_o = s_BRESP_i;
  assign s_BREADY_o  = dsp_BREADY_i[bq_head] & ~bq_empty;
  assign bq_pop      = s_BVALID_i & s_BREADY_o;

  always_comb begin
    dsp_BVALID_o = '0;
    if (!bq_empty) dsp_BVALID_o[bq_head] = s_BVALID_i;
  end

  sa_id_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (OUTSTANDING_AMT)
  ) u_wq (
    .clk_i       (ACLK_i),
    .rst_ni      (ARESETn_i),
    .push_i      (q_push),
    .push_data_i (grant_q),
    .pop_i       (wq_pop),
    .head_o      (wq_head),
    .full_o      (wq_full),
    .empty_o     (wq_empty)
  );

  sa_id_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (OUTSTANDING_AMT)
  ) u_bq (
    .clk_i       (ACLK_i),
    .rst_ni      (ARESETn_i),
    .push_i      (q_push),
    .push_data_i (grant_q),
    .pop_i       (bq_pop),
    .head_o      (bq_head),
    .full_o      (bq_full),
    .empty_o     (bq_empty)
  );

endmodule
